er_cmd_fetch: RTL and testbench

- Earthrise command fetcher: the read-side consumer of the Earthrise command list memory.
- Drives the list's Earthrise read address and absorbs its fixed 2-cycle read latency.
- Streams command words to the Earthrise drawing engine over a valid/ready handshake, stopping at a STOP word.
- Prefetches into a small internal FIFO so the drawing engine sees one command per cycle under sustained ready.

---
 rtl/er_cmd_fetch.sv | 156 +++++++++++++++
 tb/tb_er_cmd_fetch.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/er_cmd_fetch.sv
// Earthrise command fetcher: reads the command list through a 2-cycle read port,
// prefetches into a small FIFO and streams words to the drawing engine until STOP.
module er_cmd_fetch #(
  parameter int WORD       = 32,
  parameter int ADDRW      = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADDRW-1:0] start_addr,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [ADDRW-1:0] addr_er,
  input  logic [WORD-1:0]  dout_er,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [WORD-1:0]  cmd_data
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [ADDRW-1:0] addr_r;
  logic [1:0]       inflight_r;
  logic [WORD-1:0]  fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;
  logic [CW:0]      occupancy_s;
  logic             cmd_valid_r;
  logic             busy_r;
  logic             done_r;
  logic             stop_rx_s;
  logic             issue_s;
  logic             push_s;
  logic             pop_s;

  function automatic logic is_stop(input logic [WORD-1:0] w);
    return (w[WORD-1 -: 4] == 4'd0);
  endfunction

  // Next state, read issue (credit-limited) and FIFO push/pop decisions.
  always_comb begin
    state_nxt_s = state_r;
    issue_s     = 1'b0;
    push_s      = 1'b0;
    stop_rx_s   = 1'b0;
    pop_s       = cmd_valid_r & cmd_ready;
    occupancy_s = (CW+1)'(count_r) + (CW+1)'(inflight_r[0]) + (CW+1)'(inflight_r[1]);
    case (state_r)
      S_IDLE: begin
        if (start && !abort) begin
          state_nxt_s = S_FETCH;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_FETCH: begin
        stop_rx_s = inflight_r[1] & is_stop(dout_er);
        if (abort) begin
          state_nxt_s = S_IDLE;
        end else if (stop_rx_s) begin
          state_nxt_s = S_DRAIN;
        end else begin
          push_s  = inflight_r[1];
          issue_s = (occupancy_s < DEPTH_C);
        end
      end
      S_DRAIN: begin
        // Returns still in flight behind the STOP are dropped, never pushed.
        if (abort) begin
          state_nxt_s = S_IDLE;
        end else if ((count_r == {CW{1'b0}}) && (inflight_r == 2'b00)) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DRAIN;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
    count_nxt_s = count_r + CW'(push_s) - CW'(pop_s);
  end

  // Control registers: state, status flags, read address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      addr_r  <= {ADDRW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != S_IDLE);
      done_r  <= (state_r == S_DRAIN) && (state_nxt_s == S_IDLE) && !abort;
      if ((state_r == S_IDLE) && start && !abort) begin
        addr_r <= start_addr;
      end else if (issue_s) begin
        addr_r <= addr_r + ADDRW'(1);
      end else begin
        addr_r <= addr_r;
      end
    end
  end

  // In-flight tracking and the prefetch FIFO; abort flushes both.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_r  <= 2'b00;
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      cmd_valid_r <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= {WORD{1'b0}};
      end
    end else if (abort) begin
      inflight_r  <= 2'b00;
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      cmd_valid_r <= 1'b0;
    end else begin
      inflight_r  <= {inflight_r[0], issue_s};
      count_r     <= count_nxt_s;
      cmd_valid_r <= (count_nxt_s != {CW{1'b0}});
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= dout_er;
        wr_ptr_r             <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign addr_er   = addr_r;
  assign cmd_valid = cmd_valid_r;
  assign cmd_data  = fifo_mem_r[rd_ptr_r];

endmodule

// File: tb/tb_er_cmd_fetch.sv
// Directed bench for er_cmd_fetch: a 2-cycle list memory model, a scoreboard queue
// filled by the stimulus and a negedge monitor that pops and compares on transfers.
module tb_er_cmd_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  start_addr = 9'd0;
  logic        abort = 1'b0;
  logic        busy;
  logic        done;
  logic [8:0]  addr_er;
  logic [31:0] dout_er;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [31:0] cmd_data;

  er_cmd_fetch #(.WORD(32), .ADDRW(9), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .abort(abort),
    .busy(busy), .done(done), .addr_er(addr_er), .dout_er(dout_er),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [512];
  logic [31:0] rd1;
  int          cyc = 0;

  always @(posedge clk) begin
    rd1     <= mem[addr_er];
    dout_er <= rd1;
    cyc     <= cyc + 1;
  end

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q [$];
  int          xfer_q [$];
  int          addr_log [$];
  int          done_cnt = 0;
  int          valid_cnt = 0;
  int          acc_cnt = 0;
  int          acc_base = 0;
  int          run_start = 0;
  bit          chk_ahead = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: scoreboard pops, stall stability, run-ahead bound, event counters.
  always @(negedge clk) begin
    logic [31:0] exp_w;
    int          issued;
    if (done) done_cnt++;
    if (cmd_valid) valid_cnt++;
    if (prev_stall) begin
      chk("stall_valid", 32'(cmd_valid), 32'd1);
      chk("stall_data", cmd_data, prev_data);
    end
    if (cmd_valid && cmd_ready && !rst) begin
      xfer_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_cmd: got %h required none", cmd_data);
      end else begin
        exp_w = exp_q.pop_front();
        chk("cmd_data", cmd_data, exp_w);
      end
      acc_cnt++;
    end
    if (busy && (addr_log.size() == 0 || addr_log[$] != int'(addr_er)))
      addr_log.push_back(int'(addr_er));
    if (chk_ahead && busy) begin
      issued = (int'(addr_er) - run_start + 512) % 512;
      chk("run_ahead_ok", 32'(issued - (acc_cnt - acc_base) <= 4), 32'd1);
    end
    prev_stall = cmd_valid && !cmd_ready && !abort && !rst;
    prev_data  = cmd_data;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int a, output int s0);
    tick();
    start      = 1'b1;
    start_addr = 9'(a);
    s0         = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string name);
    int k = 0;
    while (busy && k < maxc) begin
      tick();
      k++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  task automatic begin_run(input int a);
    xfer_q.delete();
    addr_log.delete();
    acc_base  = acc_cnt;
    run_start = a;
  endtask

  initial begin
    int s0;
    int d0;
    int v0;
    bit bad;
    for (int i = 0; i < 512; i++) mem[i] = 32'hF000_0000 | 32'(i);

    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_data", cmd_data, 32'd0);
    chk("rst_addr", 32'(addr_er), 32'd0);
    rst = 1'b0;
    tick();

    // Basic list at 5
    mem[5] = 32'h1000_000A; mem[6] = 32'h2000_000B; mem[7] = 32'h0000_0000;
    exp_q.push_back(32'h1000_000A); exp_q.push_back(32'h2000_000B);
    cmd_ready = 1'b1;
    begin_run(5);
    d0 = done_cnt;
    pulse_start(5, s0);
    wait_idle(60, "basic_timeout");
    tick(); tick();
    if (xfer_q.size() >= 2) begin
      chk("basic_lat_first", 32'(xfer_q[0] - s0), 32'd4);
      chk("basic_lat_second", 32'(xfer_q[1] - s0), 32'd5);
    end else begin
      chk("basic_xfer_count", 32'(xfer_q.size()), 32'd2);
    end
    chk("basic_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("basic_sb_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure: 8 commands, ready pattern 1,0,0,1
    for (int i = 0; i < 8; i++) begin
      mem[i] = 32'h3000_0100 + 32'(i);
      exp_q.push_back(32'h3000_0100 + 32'(i));
    end
    mem[8] = 32'h0000_0000;
    begin_run(0);
    chk_ahead = 1'b1;
    d0 = done_cnt;
    pulse_start(0, s0);
    for (int k = 0; k < 200 && busy; k++) begin
      cmd_ready = (k % 4 == 0) || (k % 4 == 3);
      tick();
    end
    chk("bp_idle", 32'(busy), 32'd0);
    chk_ahead = 1'b0;
    cmd_ready = 1'b1;
    tick(); tick();
    chk("bp_accepted", 32'(acc_cnt - acc_base), 32'd8);
    chk("bp_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    // Address wrap
    mem[510] = 32'h1111_1111; mem[511] = 32'h1111_1112;
    mem[0] = 32'h1111_1113; mem[1] = 32'h0000_0000;
    exp_q.push_back(32'h1111_1111); exp_q.push_back(32'h1111_1112);
    exp_q.push_back(32'h1111_1113);
    begin_run(510);
    pulse_start(510, s0);
    wait_idle(60, "wrap_timeout");
    tick(); tick();
    chk("wrap_accepted", 32'(acc_cnt - acc_base), 32'd3);
    if (addr_log.size() >= 4) begin
      chk("wrap_addr0", 32'(addr_log[0]), 32'd510);
      chk("wrap_addr1", 32'(addr_log[1]), 32'd511);
      chk("wrap_addr2", 32'(addr_log[2]), 32'd0);
      chk("wrap_addr3", 32'(addr_log[3]), 32'd1);
    end else begin
      chk("wrap_addr_count", 32'(addr_log.size()), 32'd4);
    end

    // Immediate STOP
    mem[3] = 32'h0000_0000;
    begin_run(3);
    d0 = done_cnt;
    v0 = valid_cnt;
    pulse_start(3, s0);
    wait_idle(60, "istop_timeout");
    tick(); tick();
    chk("istop_valid_cycles", 32'(valid_cnt - v0), 32'd0);
    chk("istop_done_pulses", 32'(done_cnt - d0), 32'd1);

    // Abort with FIFO holding entries, then restart at 0
    for (int i = 0; i < 16; i++) mem[i] = 32'h5000_0000 + 32'(i);
    mem[16] = 32'h0000_0000;
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h5000_0000 + 32'(i));
    begin_run(0);
    d0 = done_cnt;
    pulse_start(0, s0);
    for (int k = 0; k < 40 && (acc_cnt - acc_base) < 3; k++) tick();
    cmd_ready = 1'b0;
    chk("abort_accepted", 32'(acc_cnt - acc_base), 32'd3);
    repeat (3) tick();
    chk("abort_pre_valid", 32'(cmd_valid), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", 32'(cmd_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sb_empty", 32'(exp_q.size()), 32'd0);
    repeat (4) tick();
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'h5000_0000 + 32'(i));
    cmd_ready = 1'b1;
    begin_run(0);
    d0 = done_cnt;
    pulse_start(0, s0);
    wait_idle(200, "restart_timeout");
    tick(); tick();
    chk("restart_accepted", 32'(acc_cnt - acc_base), 32'd16);
    chk("restart_done", 32'(done_cnt - d0), 32'd1);

    // start while busy is ignored
    mem[5] = 32'h1000_000A; mem[6] = 32'h2000_000B; mem[7] = 32'h0000_0000;
    exp_q.push_back(32'h1000_000A); exp_q.push_back(32'h2000_000B);
    begin_run(5);
    pulse_start(5, s0);
    tick();
    start = 1'b1; start_addr = 9'd100;
    tick();
    start = 1'b0;
    wait_idle(60, "coll_timeout");
    tick(); tick();
    chk("coll_accepted", 32'(acc_cnt - acc_base), 32'd2);
    bad = 1'b0;
    foreach (addr_log[i]) if (addr_log[i] >= 100) bad = 1'b1;
    chk("coll_no_restart_addr", 32'(bad), 32'd0);
    if (addr_log.size() >= 3) begin
      chk("coll_addr0", 32'(addr_log[0]), 32'd5);
      chk("coll_addr2", 32'(addr_log[2]), 32'd7);
    end else begin
      chk("coll_addr_count", 32'(addr_log.size()), 32'd3);
    end

    // start+abort together in IDLE
    tick();
    start = 1'b1; abort = 1'b1; start_addr = 9'd0;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", 32'(busy), 32'd0);
    repeat (5) tick();
    chk("sa_busy_later", 32'(busy), 32'd0);
    chk("sa_valid_later", 32'(cmd_valid), 32'd0);

    // rst mid-FETCH
    cmd_ready = 1'b0;
    begin_run(0);
    pulse_start(0, s0);
    repeat (3) tick();
    chk("mid_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_valid", 32'(cmd_valid), 32'd0);
    chk("mid_rst_data", cmd_data, 32'd0);
    chk("mid_rst_addr", 32'(addr_er), 32'd0);
    rst = 1'b0;
    repeat (4) tick();
    chk("mid_post_valid", 32'(cmd_valid), 32'd0);
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
